// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frame capture, receive FIFO, set-2 to ASCII ROM and hex segment drivers.
// Define PS2_PARITY_CHECK_EN to reject frames whose odd parity bit is wrong.
module ps2_keyboard_rx #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       nextdata_n,
   output logic [7:0] data,
   output logic [7:0] ascii,
   output logic       ready,
   output logic       overflow,
   output logic [3:0] count,
   output logic       sampling,
   output logic [6:0] hex0,
   output logic [6:0] hex1,
   output logic [6:0] hex2,
   output logic [6:0] hex3
);

   localparam int PW = $clog2(FIFO_DEPTH);

   logic [2:0]    sync_r;
   logic [9:0]    buffer_r;
   logic [3:0]    count_r;
   logic [7:0]    fifo_r [FIFO_DEPTH];
   logic [PW-1:0] w_ptr_r;
   logic [PW-1:0] r_ptr_r;
   logic          ready_r;
   logic          overflow_r;

   logic          sampling_s;
   logic          parity_ok_s;
   logic          frame_valid_s;
   logic          do_pop_s;
   logic [PW-1:0] w_ptr_inc_s;
   logic [PW-1:0] r_ptr_inc_s;

   function automatic logic odd_parity(input logic [8:0] bits);
      return ^bits;
   endfunction

   function automatic logic [7:0] scan_to_ascii(input logic [7:0] code);
      logic [7:0] a;
      case (code)
         8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
         8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
         8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
         8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
         8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
         8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
         8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
         8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
         8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
         8'h3E: a = 8'h38;  8'h46: a = 8'h39;
         8'h29: a = 8'h20;  8'h5A: a = 8'h0D;
         default: a = 8'h00;
      endcase
      return a;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
         4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
         4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
         4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  4'hF: s = 7'h0E;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   assign sampling_s = sync_r[2] & ~sync_r[1];

`ifdef PS2_PARITY_CHECK_EN
   assign parity_ok_s = odd_parity(buffer_r[9:1]);
`else
   logic unused_parity_s;
   assign unused_parity_s = buffer_r[9];
   assign parity_ok_s     = 1'b1;
`endif

   // Stop-bit sample decides the frame; pop is only honoured while data is held.
   always_comb begin
      frame_valid_s = sampling_s && (count_r == 4'd10) && !buffer_r[0] && ps2_data && parity_ok_s;
      do_pop_s      = ready_r && !nextdata_n;
      w_ptr_inc_s   = w_ptr_r + PW'(1);
      r_ptr_inc_s   = r_ptr_r + PW'(1);
   end

   always_ff @(posedge clk or posedge clrn) begin
      if (clrn) begin
         sync_r   <= 3'b000;
         buffer_r <= 10'd0;
         count_r  <= 4'd0;
      end else begin
         sync_r <= {sync_r[1:0], ps2_clk};
         if (sampling_s) begin
            if (count_r < 4'd10) begin
               buffer_r[count_r] <= ps2_data;
               count_r           <= count_r + 4'd1;
            end else begin
               count_r <= 4'd0;
            end
         end
      end
   end

   // A write in the same cycle as the emptying pop keeps ready high.
   always_ff @(posedge clk or posedge clrn) begin
      if (clrn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_r[i] <= 8'h00;
         w_ptr_r    <= '0;
         r_ptr_r    <= '0;
         ready_r    <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         if (frame_valid_s) begin
            fifo_r[w_ptr_r] <= buffer_r[8:1];
            w_ptr_r         <= w_ptr_inc_s;
            if (r_ptr_r == w_ptr_inc_s) overflow_r <= 1'b1;
         end
         if (do_pop_s) r_ptr_r <= r_ptr_inc_s;
         if (frame_valid_s) begin
            ready_r <= 1'b1;
         end else if (do_pop_s && (r_ptr_inc_s == w_ptr_r)) begin
            ready_r <= 1'b0;
         end
      end
   end

   assign data     = fifo_r[r_ptr_r];
   assign ascii    = scan_to_ascii(data);
   assign ready    = ready_r;
   assign overflow = overflow_r;
   assign count    = count_r;
   assign sampling = sampling_s;
   assign hex0     = seg7(data[3:0]);
   assign hex1     = seg7(data[7:4]);
   assign hex2     = seg7(ascii[3:0]);
   assign hex3     = seg7(ascii[7:4]);

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: directed steps plus randomized frames against a queue-style model.
module tb_ps2_keyboard_rx;

   localparam int DEPTH = 8;
`ifdef PS2_PARITY_CHECK_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       clrn, ps2_clk, ps2_data, nextdata_n;
   logic [7:0] data, ascii;
   logic       ready, overflow, sampling;
   logic [3:0] count;
   logic [6:0] hex0, hex1, hex2, hex3;

   int total = 0;
   int bad   = 0;
   int samp_seen = 0;

   logic [7:0] mem [DEPTH];
   int         wr, rd;
   logic       ovf_m;
   logic [7:0] asc_tab [256];
   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [7:0] codes [36] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                              8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                              8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
                              8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
   string chars = "abcdefghijklmnopqrstuvwxyz0123456789";

   always #5 clk = ~clk;

   always @(posedge clk) if (sampling) samp_seen <= samp_seen + 1;

   ps2_keyboard_rx #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .nextdata_n(nextdata_n),
      .data(data), .ascii(ascii), .ready(ready), .overflow(overflow), .count(count),
      .sampling(sampling), .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
      wr = 0; rd = 0; ovf_m = 1'b0;
   endtask

   task automatic model_write(input logic [7:0] b);
      if (wr - rd == DEPTH - 1) ovf_m = 1'b1;
      mem[wr % DEPTH] = b;
      wr++;
   endtask

   task automatic model_pop();
      if (wr != rd) rd++;
   endtask

   task automatic check_outputs(input string tag);
      logic [7:0] d, a;
      d = mem[rd % DEPTH];
      a = asc_tab[d];
      check({tag, "_ready"}, {7'd0, ready}, {7'd0, wr != rd});
      check({tag, "_data"}, data, d);
      check({tag, "_ascii"}, ascii, a);
      check({tag, "_ovf"}, {7'd0, overflow}, {7'd0, ovf_m});
      check({tag, "_hex0"}, {1'b0, hex0}, {1'b0, seg_tab[d[3:0]]});
      check({tag, "_hex1"}, {1'b0, hex1}, {1'b0, seg_tab[d[7:4]]});
      check({tag, "_hex2"}, {1'b0, hex2}, {1'b0, seg_tab[a[3:0]]});
      check({tag, "_hex3"}, {1'b0, hex3}, {1'b0, seg_tab[a[7:4]]});
   endtask

   task automatic do_reset();
      clrn = 1'b1;
      repeat (3) @(negedge clk);
      clrn = 1'b0;
      @(negedge clk);
      model_reset();
   endtask

   // One PS/2 bit; optionally pulses nextdata_n so it lands on the same edge as a stop-bit write.
   task automatic ps2_bit(input logic b, input bit pop_here);
      ps2_data = b;
      repeat (4) @(negedge clk);
      ps2_clk = 1'b0;
      if (pop_here) begin
         repeat (2) @(negedge clk);
         nextdata_n = 1'b0;
         @(negedge clk);
         nextdata_n = 1'b1;
         repeat (5) @(negedge clk);
      end else begin
         repeat (8) @(negedge clk);
      end
      ps2_clk = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   // kind: 0 good, 1 bad parity, 2 bad stop, 3 bad start
   task automatic send_frame(input logic [7:0] b, input int kind, input bit chk_cnt, input bit pop_stop);
      logic [10:0] f;
      int          s0;
      bit          valid, had;
      f[0]   = (kind == 3);
      f[8:1] = b;
      f[9]   = (kind == 1) ? ^b : ~^b;
      f[10]  = (kind != 2);
      s0 = samp_seen;
      for (int i = 0; i < 11; i++) begin
         ps2_bit(f[i], pop_stop && (i == 10));
         if (chk_cnt) check("count_step", {4'd0, count}, 8'((i + 1) % 11));
      end
      check("sample_strobes", 8'(samp_seen - s0), 8'd11);
      valid = (kind == 0) || ((kind == 1) && !PAR_EN);
      had = (wr != rd);
      if (valid) model_write(b);
      if (pop_stop && had) rd++;
   endtask

   task automatic pop();
      nextdata_n = 1'b0;
      @(negedge clk);
      nextdata_n = 1'b1;
      @(negedge clk);
      model_pop();
   endtask

   initial begin
      logic [7:0] b;
      int         r, kind;
      bit         ps;
      for (int i = 0; i < 256; i++) asc_tab[i] = 8'h00;
      for (int i = 0; i < 36; i++) asc_tab[codes[i]] = chars[i];
      asc_tab[8'h29] = 8'h20;
      asc_tab[8'h5A] = 8'h0D;
      clrn = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1;

      do_reset();
      check_outputs("reset");
      check("reset_count", {4'd0, count}, 8'd0);
      check("reset_sampling", {7'd0, sampling}, 8'd0);
      check("reset_hex3", {1'b0, hex3}, 8'h40);
      repeat (20) @(negedge clk);
      check_outputs("idle");
      check("idle_count", {4'd0, count}, 8'd0);

      send_frame(8'h1C, 0, 1'b1, 1'b0);
      check_outputs("f1c");
      check("f1c_ascii_const", ascii, 8'h61);
      check("f1c_hex0_const", {1'b0, hex0}, 8'h46);
      check("f1c_hex3_const", {1'b0, hex3}, 8'h02);

      pop();
      check_outputs("pop1");
      check("pop1_data_const", data, 8'h00);
      pop();
      check_outputs("pop_empty");

      send_frame(8'h1C, 1, 1'b0, 1'b0);
      check_outputs("bad_parity");
      send_frame(8'h55, 2, 1'b0, 1'b0);
      check_outputs("bad_stop");
      send_frame(8'h33, 3, 1'b0, 1'b0);
      check_outputs("bad_start");
      for (int i = 0; i < DEPTH && wr != rd; i++) pop();
      check_outputs("drained");

      send_frame(8'h24, 0, 1'b0, 1'b0);
      send_frame(8'h44, 0, 1'b0, 1'b1);
      check_outputs("simul_pop_write");
      pop();
      check_outputs("simul_after");

      for (int i = 0; i < 4; i++) ps2_bit(1'b0, 1'b0);
      do_reset();
      check("midreset_count", {4'd0, count}, 8'd0);
      send_frame(8'h2B, 0, 1'b1, 1'b0);
      check_outputs("midreset_frame");

      do_reset();
      for (int k = 0; k < 8; k++) begin
         send_frame(8'h16 + 8'(k), 0, 1'b0, 1'b0);
         check_outputs("ovf_fill");
      end
      check("ovf_set_const", {7'd0, overflow}, 8'd1);
      for (int k = 0; k < 8; k++) begin
         pop();
         check_outputs("ovf_drain");
      end
      check("ovf_sticky_const", {7'd0, overflow}, 8'd1);
      do_reset();
      check_outputs("ovf_cleared");

      send_frame(8'hF0, 0, 1'b0, 1'b0);
      send_frame(8'h1C, 0, 1'b0, 1'b0);
      check_outputs("break_f0");
      check("break_ascii_const", ascii, 8'h00);
      pop();
      check_outputs("break_1c");
      check("break_1c_ascii_const", ascii, 8'h61);
      pop();

      for (int n = 0; n < 30; n++) begin
         b = ($urandom_range(0, 1) == 0) ? codes[$urandom_range(0, 35)] : 8'($urandom);
         r = $urandom_range(0, 7);
         kind = (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 3 : 0;
         ps = ($urandom_range(0, 5) == 0);
         if (wr - rd == DEPTH) pop();
         send_frame(b, kind, 1'b0, ps);
         check_outputs("rand_frame");
         r = $urandom_range(0, 2);
         for (int p = 0; p < r; p++) begin
            pop();
            check_outputs("rand_pop");
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, power of two, number of receive FIFO entries.
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-003 SHALL have port clrn, input, 1 bit: asynchronous active-high reset; the name is kept from the codebase, and the polarity is active-high.
REQ-004 SHALL have ports ps2_clk and ps2_data, each input, 1 bit: raw PS/2 lines, asynchronous to clk.
REQ-005 SHALL have port nextdata_n, input, 1 bit: active-low read acknowledge that pops the FIFO head.
REQ-006 SHALL have port data, output, 8 bits: scan code at the FIFO head.
REQ-007 SHALL have port ascii, output, 8 bits: ASCII translation of data.
REQ-008 SHALL have port ready, output, 1 bit: FIFO non-empty.
REQ-009 SHALL have port overflow, output, 1 bit: sticky overflow flag.
REQ-010 SHALL have port count, output, 4 bits: frame bit counter.
REQ-011 SHALL have port sampling, output, 1 bit: one-cycle strobe on each synchronised ps2_clk falling edge.
REQ-012 SHALL have ports hex0, hex1, hex2, hex3, each output, 7 bits, active-low segments {g,f,e,d,c,b,a}: data[3:0], data[7:4], ascii[3:0], ascii[7:4] respectively.

Function
REQ-013 SHALL synchronise ps2_clk through a 3-flop shift register; sampling = older & ~newer, combinational from the flops.
REQ-014 On sampling with count<10: buffer[count] <= ps2_data; count <= count+1.
REQ-015 On sampling with count==10, frame validation: count <= 0; frame valid iff start bit buffer[0]==0, ps2_data (stop bit)==1, and the parity check of REQ-032 passes.
REQ-016 Valid frame: fifo[w_ptr] <= buffer[8:1] (LSB first); w_ptr increments mod FIFO_DEPTH; ready <= 1.
REQ-017 Invalid frame: no FIFO write, no flag change.
REQ-018 data = fifo[r_ptr], combinational; ready and data change on the clock after the stop-bit sample.
REQ-019 When ready==1 and nextdata_n==0 on a clock edge: r_ptr increments; ready <= 0 if the new r_ptr equals w_ptr.
REQ-020 When ready==0, nextdata_n SHALL be ignored.
REQ-021 Simultaneous pop and valid write: both occur; ready ends 1 (write wins).
REQ-022 Overflow: on a valid write when r_ptr == w_ptr+1, overflow <= 1; the write still occurs; overflow holds until reset.
REQ-023 The ROM SHALL be combinational, mapping set-2 scan code to ASCII:
- Letters to lowercase: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z.
- Digits: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'.
- Other: 29 to 0x20, 5A to 0x0D.
- All other codes, including F0 and E0, to 0x00.
REQ-024 The segment decoder SHALL be combinational, with the following hex outputs: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 B:03 C:46 D:21 E:06 F:0E.
REQ-025 count SHALL wrap only via REQ-015; it never exceeds 10.

Reset
REQ-026 While clrn==1, the following SHALL be cleared asynchronously: sync flops, buffer, count, w_ptr, r_ptr, ready, overflow, and all FIFO entries.
REQ-027 Post-reset outputs SHALL be: data=0x00, ascii=0x00, ready=0, overflow=0, count=0, sampling=0, hex0..hex3=0x40.
REQ-028 Reset mid-frame SHALL discard the partial frame; reception restarts at the next start bit.

Configuration
REQ-029 The macro PS2_PARITY_CHECK_EN SHALL select parity handling.
REQ-030 With the macro defined, validity additionally requires odd parity, i.e. XOR(buffer[9:1])==1.
REQ-031 Without the macro, the parity bit SHALL be ignored.
REQ-032 The parity check referenced by REQ-015 is the one selected by REQ-029 to REQ-031.

Verification
REQ-033 Reset then idle lines -> ready=0, overflow=0, count=0, hex0..hex3=0x40.
REQ-034 Send frame 0x1C with good parity -> count steps 1..10 then 0; ready=1, data=0x1C, ascii=0x61, hex0=0x46, hex1=0x79, hex2=0x79, hex3=0x02.
REQ-035 With ready=1, pulse nextdata_n=0 for one cycle -> ready=0 next cycle; data stays fifo[1]=0x00.
REQ-036 With the macro defined, send 0x1C with bad parity -> ready stays 0, no write; without the macro -> accepted.
REQ-037 Send 8 frames 0x16..0x1D with no reads -> overflow=1 after the 8th write and stays 1 after pops, until clrn.
REQ-038 Send F0 then 1C -> data=0xF0, ascii=0x00; after a pop, data=0x1C, ascii=0x61.
